// File: rtl/xbar_pkg.sv
// Shared helpers for the parametrised lane crossbar.
// Holds the select-width derivation, the identity routing map and the
// lane slice helpers for flat data/select buses. The MAX_* bounds size
// the helper return values; the top casts them down to its real widths.
package xbar_pkg;

    localparam int unsigned MAX_CH     = 16;
    localparam int unsigned MAX_SEL_W  = 4;
    localparam int unsigned MAX_DATA_W = 32;
    localparam int unsigned MAP_W      = MAX_CH * MAX_SEL_W;
    localparam int unsigned BUS_W      = MAX_CH * MAX_DATA_W;

    // Ceiling log2. Returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = (n > 0) ? n - 1 : 0; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Per-output select width; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    // Flat map in which output j selects input j.
    function automatic logic [MAP_W-1:0] identity_map(input int unsigned n,
                                                      input int unsigned sw);
        logic [MAP_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            for (int unsigned b = 0; b < MAX_SEL_W; b++) begin
                if (i < n && b < sw) begin
                    m[i*sw + b] = i[b];
                end
            end
        end
        return m;
    endfunction

    // Select field of output j from a flat map.
    function automatic logic [MAX_SEL_W-1:0] sel_slice(input logic [MAP_W-1:0] map,
                                                       input int unsigned j,
                                                       input int unsigned sw);
        logic [MAX_SEL_W-1:0] s;
        s = '0;
        for (int unsigned b = 0; b < MAX_SEL_W; b++) begin
            if (b < sw) begin
                s[b] = map[j*sw + b];
            end
        end
        return s;
    endfunction

    // Data lane i from a flat lane bus.
    function automatic logic [MAX_DATA_W-1:0] data_slice(input logic [BUS_W-1:0] bus,
                                                         input int unsigned i,
                                                         input int unsigned w);
        logic [MAX_DATA_W-1:0] d;
        d = '0;
        for (int unsigned b = 0; b < MAX_DATA_W; b++) begin
            if (b < w) begin
                d[b] = bus[i*w + b];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/xbar_lane_pipe.sv
// Enabled shift register carrying one crossbar output lane.
// Ports: clk, reset_n (sync active-low clear), en (advance),
//        d (mux result), q (last stage).
module xbar_lane_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] stage_q [DEPTH];

    // Stage 0 takes the mux output; later stages shift on each enabled edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= d;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/param_xbar_pipe.sv
// NUM_CH x NUM_CH lane crossbar with a runtime routing map and a
// PIPE_DEPTH-deep enabled output pipeline (DATA_W up to 32).
// Ports: clk, reset_n (sync active-low), io_clk_en (pipeline advance),
//        io_in_valid/io_input (lane bus), io_cfg_valid/io_cfg_ready/io_cfg_sel
//        (routing map handshake), io_output/io_out_valid (routed lanes),
//        io_sel_err (sticky out-of-range select committed).
module param_xbar_pipe
    import xbar_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 5,
    parameter  int unsigned DATA_W     = 8,
    parameter  int unsigned PIPE_DEPTH = 1,
    localparam int unsigned SEL_W      = sel_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     io_clk_en,
    input  logic                     io_in_valid,
    input  logic [NUM_CH*DATA_W-1:0] io_input,
    input  logic                     io_cfg_valid,
    output logic                     io_cfg_ready,
    input  logic [NUM_CH*SEL_W-1:0]  io_cfg_sel,
    output logic [NUM_CH*DATA_W-1:0] io_output,
    output logic                     io_out_valid,
    output logic                     io_sel_err
);

    localparam int unsigned MAP_BITS = NUM_CH * SEL_W;

    logic [MAP_BITS-1:0]   active_q;
    logic [MAP_BITS-1:0]   pend_map_q;
    logic                  pending_q;
    logic                  err_q;
    logic [PIPE_DEPTH-1:0] vld_q;

    logic [DATA_W-1:0] lane_in_c  [NUM_CH];
    logic [SEL_W-1:0]  act_sel_c  [NUM_CH];
    logic [SEL_W-1:0]  pend_sel_c [NUM_CH];
    logic [DATA_W-1:0] mux_c      [NUM_CH];
    logic              pend_bad_c;

    // Unpack the flat buses into per-lane views.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign lane_in_c[i]  = DATA_W'(data_slice(BUS_W'(io_input), i, DATA_W));
        assign act_sel_c[i]  = SEL_W'(sel_slice(MAP_W'(active_q), i, SEL_W));
        assign pend_sel_c[i] = SEL_W'(sel_slice(MAP_W'(pend_map_q), i, SEL_W));
    end

    // Output mux: an out-of-range select matches no input and yields zero.
    always_comb begin
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            mux_c[j] = '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (act_sel_c[j] == SEL_W'(i)) begin
                    mux_c[j] = lane_in_c[i];
                end
            end
        end
    end

    // Any out-of-range entry in the map about to be committed.
    always_comb begin
        pend_bad_c = 1'b0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (32'(pend_sel_c[j]) >= NUM_CH) begin
                pend_bad_c = 1'b1;
            end
        end
    end

    // Map registers, handshake and valid pipe. Accept needs ready (!pending),
    // commit needs pending, so the two never share an edge. The mux reads
    // active_q, so data captured on the commit edge still uses the old map.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active_q   <= MAP_BITS'(identity_map(NUM_CH, SEL_W));
            pend_map_q <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= '0;
        end else begin
            if (io_cfg_valid && !pending_q) begin
                pend_map_q <= io_cfg_sel;
                pending_q  <= 1'b1;
            end else if (io_clk_en && pending_q) begin
                active_q  <= pend_map_q;
                pending_q <= 1'b0;
                if (pend_bad_c) begin
                    err_q <= 1'b1;
                end
            end
            if (io_clk_en) begin
                vld_q[0] <= io_in_valid;
                for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_CH; j++) begin : g_lane
        xbar_lane_pipe #(
            .DATA_W (DATA_W),
            .DEPTH  (PIPE_DEPTH)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (io_clk_en),
            .d       (mux_c[j]),
            .q       (io_output[j*DATA_W +: DATA_W])
        );
    end

    assign io_cfg_ready = !pending_q;
    assign io_out_valid = vld_q[PIPE_DEPTH-1];
    assign io_sel_err   = err_q;

endmodule

// File: doc/param_xbar_pipe.md
Name: param_xbar_pipe

Overview:
- Parametrised successor to the 5x8-bit registered lane block; a true NUM_CH x NUM_CH crossbar with a runtime routing map.
- Each output selects any input through a configurable pipeline of PIPE_DEPTH stages, gated by io_clk_en.
- Routing changes arrive over a valid/ready config handshake. They commit glitch-free at a defined pipeline boundary.
- Sits between convolution datapath stages to permute channel lanes.

Parameters:
NUM_CH, 5, number of input and output lanes (2..16)
DATA_W, 8, bits per lane
PIPE_DEPTH, 1, register stages from mux to output (1..4)
SEL_W, clog2(NUM_CH), per-output select width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
io_clk_en  in  1  pipeline advance enable; 0 = all data/valid stages hold
io_in_valid  in  1  qualifies io_input for the current cycle
io_input  in  NUM_CH*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
io_cfg_valid  in  1  new routing map offered
io_cfg_ready  out  1  map can be accepted
io_cfg_sel  in  NUM_CH*SEL_W  output j selects input io_cfg_sel[j*SEL_W +: SEL_W]
io_output  out  NUM_CH*DATA_W  routed lanes, from last pipe stage
io_out_valid  out  1  io_in_valid delayed by PIPE_DEPTH enabled cycles
io_sel_err  out  1  sticky: an out-of-range select was committed

Behaviour:
- Reset (reset_n=0 at edge): all pipe data regs 0, valid regs 0. Active map = identity (out j <- in j). Pending flag 0, io_cfg_ready=1, io_sel_err=0. Reset overrides io_clk_en and the handshake.
- Datapath: stage1[j] <= active[j] < NUM_CH ? input[active[j]] : 0; stage k <= stage k-1. All move only on edges with io_clk_en=1.
- io_output = stage PIPE_DEPTH.
- Latency = PIPE_DEPTH enabled edges. With PIPE_DEPTH=1 and identity map, behaviour equals the prior registered lane block.
- Valid pipe is parallel to data, same enable. Data stages load regardless of valid: no bubble squashing, data is don't-care when valid=0.
- io_clk_en=0: data, valid and active map hold; io_output constant.
- Config handshake:
  - Accept at an edge with io_cfg_valid & io_cfg_ready: pending_map <= io_cfg_sel, pending <= 1.
  - io_cfg_ready = !pending (combinational from the flag only, no dependence on io_cfg_valid).
- Commit: at the first edge with io_clk_en=1 and pending=1, active <= pending_map and pending <= 0.
  - Data captured at that same edge uses the OLD map.
  - First sample routed by the new map is captured at the next enabled edge.
- Accept and commit cannot coincide (ready=0 while pending). An accept on an enabled edge only loads pending; commit waits for a later enabled edge.
- io_cfg_valid with ready=0: ignored; the source must hold until ready.
- Out-of-range select (>= NUM_CH, possible when NUM_CH is not a power of 2): lane outputs 0. io_sel_err sets at the commit edge and stays set until reset.
- Duplicate selects are legal (broadcast).
- Reset mid-config: pending discarded and map returns to identity.

Decomposition:
- Package xbar_pkg holds:
  - clog2 function
  - SEL_W derivation
  - identity-map generator function
  - lane slice helper functions for data and select.
- One sub-module is natural: xbar_lane_pipe. It is a DATA_W-wide, PIPE_DEPTH-deep enabled shift register with synchronous active-low clear, instantiated once per output lane. The top holds the muxes, map registers, handshake and valid pipe.

Test Plan:
- Reset then identity, PIPE_DEPTH=1: inputs 0x10..0x14, io_clk_en=1, valid=1 -> one edge later outputs 0x10..0x14, io_out_valid=1.
- Reverse map: cfg_sel={0,1,2,3,4} for outputs 4..0 (out j <- in 4-j), cfg_valid one cycle -> ready drops for one cycle. Sample at the commit edge exits with identity. Next sample exits reversed: out0=0x14 … out4=0x10.
- Stall with PIPE_DEPTH=3: stream 0x01,0x02,0x03 with io_clk_en low for 5 cycles mid-stream -> outputs and io_out_valid frozen during the stall. Each sample appears exactly 3 enabled edges after entry, none lost or duplicated.
- Pending blocks, clk_en=0: map offered with io_clk_en=0 for 4 cycles -> pending=1, io_cfg_ready=0 throughout. A second offer is not accepted. Commit happens on the first enabled edge.
- Out-of-range select: NUM_CH=5, out2 sel=7 committed -> io_output lane 2 = 0x00 from the next capture. io_sel_err=1 and stays 1 after a valid map is committed. Cleared only by reset_n=0.
- Reset mid-operation: reset_n=0 for one edge while pending=1 and pipe full -> outputs 0, io_out_valid=0, io_cfg_ready=1. Map is identity on the next enabled capture.
